// File: rtl/ahb_lite_modport_pkg.sv
// Shared AHB-Lite widths, encodings and the byte-lane strobe helper.
package ahb_lite_pkg;

  localparam int unsigned ADDR_W                = 32;
  localparam int unsigned DATA_W                = 32;
  localparam int unsigned TRANS_W               = 2;
  localparam int unsigned SIZE_W                = 3;
  localparam int unsigned BURST_W               = 3;
  localparam int unsigned PROT_W                = 4;
  localparam int unsigned RESP_W                = 1;
  localparam int unsigned READY_W               = 1;
  localparam int unsigned BITS_FOR_SUBORDINATES = 2;
  localparam int unsigned STRB_W                = DATA_W / 8;

  typedef enum logic [TRANS_W-1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } HTRANS_e;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } HSIZE_e;

  typedef enum logic [BURST_W-1:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } HBURST_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } HRESP_e;

  typedef enum logic [READY_W-1:0] {
    READY_WAIT = 1'b0,
    READY_DONE = 1'b1
  } HREADY_e;

  typedef enum logic {
    WRITE_READ  = 1'b0,
    WRITE_WRITE = 1'b1
  } HWRITE_e;

  typedef enum logic {
    RESET_ACTIVE   = 1'b0,
    RESET_INACTIVE = 1'b1
  } HRESET_e;

  // Little-endian lane enables for a (size, byte offset) pair.
  function automatic logic [STRB_W-1:0] lane_strobe(input logic [SIZE_W-1:0] size,
                                                    input logic [1:0]        off);
    logic [STRB_W-1:0] s;
    case (size)
      SIZE_BYTE: s = 4'b0001 << off;
      SIZE_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default:   s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ahb_lite_modport_if.sv
// AHB-Lite bus bundle between the single manager and the subordinate subsystem.
interface ahb_lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import ahb_lite_pkg::*;

  logic                  HWRITE;
  logic [TRANS_W-1:0]    HTRANS;
  logic [SIZE_W-1:0]     HSIZE;
  logic [BURST_W-1:0]    HBURST;
  logic [PROT_W-1:0]     HPROT;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HRESP;
  logic                  HREADY;

  modport master (
    output HWRITE, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    input  HRDATA, HRESP, HREADY
  );

  modport slave (
    input  HWRITE, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    output HRDATA, HRESP, HREADY
  );

endinterface

// File: rtl/ahb_lite_modport_mem_sub.sv
// Word-addressed memory subordinate: byte-lane write, combinational read port.
module ahb_lite_mem_sub
  import ahb_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         HRESETn,
  input  logic                         HSELx,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx,
  input  logic [DATA_WIDTH/8-1:0]      strb,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Storage: cleared on reset, enabled lanes updated at the end of a write data phase.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (HSELx && we) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read port: full addressed word, lanes not masked.
  always_comb rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_modport.sv
// AHB-Lite subordinate subsystem: decode, error check, response FSM, read mux.
module ahb_lite_modport
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH            = 32,
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned BITS_FOR_SUBORDINATES = 2,
  parameter int unsigned MEM_DEPTH             = 16
) (
  input  logic       clk,
  input  logic       HRESETn,
  ahb_lite_if.slave  bus
);

  localparam int unsigned NSUB    = 2 ** BITS_FOR_SUBORDINATES;
  localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_MSB = IDX_W + 1;
  localparam int unsigned SEL_LSB = ADDR_WIDTH - BITS_FOR_SUBORDINATES;

  typedef enum logic [1:0] {IDLE_OK, DATA, ERR1, ERR2} state_e;

  state_e                           state, state_n;
  logic                             a_valid, a_bad;
  logic [BITS_FOR_SUBORDINATES-1:0] d_sel;
  logic [IDX_W-1:0]                 d_idx;
  logic [SIZE_W-1:0]                d_size;
  logic                             d_write;
  logic [1:0]                       d_off;
  logic [DATA_WIDTH/8-1:0]          d_strb;
  logic                             d_we;
  logic [NSUB-1:0]                  hsel;
  logic [DATA_WIDTH-1:0]            sub_rdata [NSUB];
  logic                             unused_ok;

  // HBURST/HPROT carry no state: each beat supplies its own address.
  assign unused_ok = ^{bus.HBURST, bus.HPROT};

  // Address-phase acceptance, legality check and next-state selection.
  always_comb begin
    a_valid = (state != ERR1) &&
              (bus.HTRANS == TRANS_NONSEQ || bus.HTRANS == TRANS_SEQ);
    a_bad   = (bus.HSIZE > SIZE_WORD) ||
              (bus.HSIZE == SIZE_HALF && bus.HADDR[0]) ||
              (bus.HSIZE == SIZE_WORD && (|bus.HADDR[1:0])) ||
              (|bus.HADDR[SEL_LSB-1:IDX_MSB+1]);
    state_n = IDLE_OK;
    if (a_valid) state_n = a_bad ? ERR1 : DATA;
    else if (state == ERR1) state_n = ERR2;
  end

  // Response state register.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE_OK;
    else          state <= state_n;
  end

  // Pending data-phase attributes, captured on a legal accept.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      d_sel   <= '0;
      d_idx   <= '0;
      d_size  <= '0;
      d_write <= 1'b0;
      d_off   <= '0;
    end else if (a_valid && !a_bad) begin
      d_sel   <= bus.HADDR[ADDR_WIDTH-1:SEL_LSB];
      d_idx   <= bus.HADDR[IDX_MSB:IDX_LSB];
      d_size  <= bus.HSIZE;
      d_write <= bus.HWRITE;
      d_off   <= bus.HADDR[1:0];
    end
  end

  // Data-phase write control and subordinate select decode.
  always_comb begin
    d_strb = lane_strobe(d_size, d_off);
    d_we   = (state == DATA) && d_write;
    hsel   = '0;
    for (int unsigned s = 0; s < NSUB; s++) begin
      hsel[s] = (d_sel == BITS_FOR_SUBORDINATES'(s));
    end
  end

  for (genvar s = 0; s < NSUB; s++) begin : g_sub
    ahb_lite_mem_sub #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
      .clk     (clk),
      .HRESETn (HRESETn),
      .HSELx   (hsel[s]),
      .we      (d_we),
      .idx     (d_idx),
      .strb    (d_strb),
      .wdata   (bus.HWDATA),
      .rdata   (sub_rdata[s])
    );
  end

  // Manager-facing response: wait only in ERR1, ERROR across both error cycles.
  always_comb begin
    bus.HREADY = (state != ERR1);
    bus.HRESP  = (state == ERR1) || (state == ERR2);
    bus.HRDATA = (state == DATA && !d_write) ? sub_rdata[d_sel] : '0;
  end

endmodule

// File: tb/tb_ahb_lite_modport.sv
module tb_ahb_lite_modport;

  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NS = 2'd2, T_SQ = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_ready;
    logic        e_resp;
    logic [31:0] e_rdata;
    bit          chk_rd;
  } vec_t;

  logic clk = 1'b0;
  logic HRESETn;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  ahb_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_lite_modport #(
    .ADDR_WIDTH            (32),
    .DATA_WIDTH            (32),
    .BITS_FOR_SUBORDINATES (2),
    .MEM_DEPTH             (16)
  ) dut (
    .clk     (clk),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] t, input logic w, input logic [2:0] sz,
                     input logic [2:0] bu, input logic [31:0] a, input logic [31:0] wd,
                     input logic er, input logic ep, input logic [31:0] erd, input bit ck);
    vec_t v;
    v.trans = t; v.write = w; v.size = sz; v.burst = bu; v.addr = a; v.wdata = wd;
    v.e_ready = er; v.e_resp = ep; v.e_rdata = erd; v.chk_rd = ck;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.HTRANS = t; bus.HWRITE = w; bus.HSIZE = sz; bus.HADDR = a; bus.HWDATA = wd;
    bus.HBURST = B_SINGLE; bus.HPROT = 4'h3;
  endtask

  task automatic check_out(input string tag, input logic er, input logic ep, input logic [31:0] erd);
    check({tag, " HREADY"}, 32'(bus.HREADY), 32'(er));
    check({tag, " HRESP"},  32'(bus.HRESP),  32'(ep));
    check({tag, " HRDATA"}, bus.HRDATA, erd);
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);

    // One row per cycle: inputs for this cycle, outputs expected for this cycle.
    add(T_NS,   1, 2, B_SINGLE, 32'h4000_0008, 32'h0,         1, 0, 32'h0,         1);
    add(T_NS,   0, 2, B_SINGLE, 32'h4000_0008, 32'hDEAD_BEEF, 1, 0, 32'h0,         0);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 0, 32'hDEAD_BEEF, 1);
    add(T_NS,   0, 2, B_SINGLE, 32'h0000_0004, 32'h0,         1, 0, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 0, 32'h0,         1);
    add(T_NS,   1, 2, B_SINGLE, 32'h0000_0000, 32'h0,         1, 0, 32'h0,         1);
    add(T_NS,   1, 0, B_SINGLE, 32'h0000_0001, 32'h1122_3344, 1, 0, 32'h0,         0);
    add(T_NS,   0, 2, B_SINGLE, 32'h0000_0000, 32'hFFFF_AAFF, 1, 0, 32'h0,         0);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 0, 32'h1122_AA44, 1);
    add(T_NS,   1, 1, B_SINGLE, 32'h0000_0003, 32'h0,         1, 0, 32'h0,         1);
    add(T_NS,   1, 2, B_SINGLE, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'hFFFF_FFFF, 1, 1, 32'h0,         1);
    add(T_NS,   0, 2, B_SINGLE, 32'h0000_0000, 32'h0,         1, 0, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 0, 32'h1122_AA44, 1);
    add(T_NS,   0, 3, B_SINGLE, 32'h0000_0000, 32'h0,         1, 0, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         0, 1, 32'h0,         1);
    add(T_NS,   0, 2, B_SINGLE, 32'h0000_0040, 32'h0,         1, 1, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         0, 1, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 1, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 0, 32'h0,         1);
    add(T_NS,   1, 2, B_SINGLE, 32'h0000_0002, 32'h0,         1, 0, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'hFFFF_FFFF, 0, 1, 32'h0,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 1, 32'h0,         1);
    add(T_NS,   0, 2, B_SINGLE, 32'h0000_0000, 32'h0,         1, 0, 32'h0,         1);
    add(T_NS,   1, 2, B_INCR4,  32'h8000_0000, 32'h0,         1, 0, 32'h1122_AA44, 1);
    add(T_SQ,   1, 2, B_INCR4,  32'h8000_0004, 32'd1,         1, 0, 32'h0,         0);
    add(T_BUSY, 1, 2, B_INCR4,  32'h8000_0008, 32'd2,         1, 0, 32'h0,         0);
    add(T_SQ,   1, 2, B_INCR4,  32'h8000_0008, 32'h0,         1, 0, 32'h0,         1);
    add(T_SQ,   1, 2, B_INCR4,  32'h8000_000C, 32'd3,         1, 0, 32'h0,         0);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'd4,         1, 0, 32'h0,         0);
    add(T_NS,   0, 2, B_INCR4,  32'h8000_0000, 32'h0,         1, 0, 32'h0,         1);
    add(T_SQ,   0, 2, B_INCR4,  32'h8000_0004, 32'h0,         1, 0, 32'd1,         1);
    add(T_SQ,   0, 2, B_INCR4,  32'h8000_0008, 32'h0,         1, 0, 32'd2,         1);
    add(T_SQ,   0, 2, B_INCR4,  32'h8000_000C, 32'h0,         1, 0, 32'd3,         1);
    add(T_BUSY, 0, 2, B_INCR4,  32'h8000_0010, 32'h0,         1, 0, 32'd4,         1);
    add(T_IDLE, 0, 2, B_SINGLE, 32'h0,         32'h0,         1, 0, 32'h0,         1);

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b1, 1'b0, 32'h0);
    HRESETn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].trans, vecs[i].write, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      bus.HBURST = vecs[i].burst;
      #1;
      check($sformatf("row%0d HREADY", i), 32'(bus.HREADY), 32'(vecs[i].e_ready));
      check($sformatf("row%0d HRESP", i),  32'(bus.HRESP),  32'(vecs[i].e_resp));
      if (vecs[i].chk_rd) check($sformatf("row%0d HRDATA", i), bus.HRDATA, vecs[i].e_rdata);
      @(posedge clk);
      #1;
    end

    // Reset during a read data phase drops HRDATA at once; then during a write data phase.
    drive(T_NS, 1'b0, 3'd2, 32'h4000_0008, 32'h0);
    @(posedge clk); #1;
    drive(T_NS, 1'b1, 3'd2, 32'hC000_0010, 32'h0);
    #1;
    check_out("rd before rst", 1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    HRESETn = 1'b0;
    #1;
    check_out("rst in rd data", 1'b1, 1'b0, 32'h0);
    HRESETn = 1'b1;
    @(posedge clk); #1;
    drive(T_NS, 1'b1, 3'd2, 32'hC000_0010, 32'h0);
    @(posedge clk); #1;
    drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'h1234_5678);
    #1;
    HRESETn = 1'b0;
    #1;
    check_out("rst in wr data", 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    HRESETn = 1'b1;
    drive(T_NS, 1'b0, 3'd2, 32'hC000_0010, 32'h0);
    @(posedge clk); #1;
    drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    #1;
    check_out("aborted wr rd", 1'b1, 1'b0, 32'h0);

    // Reset in ERR1 releases the wait state asynchronously.
    drive(T_NS, 1'b0, 3'd4, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(T_IDLE, 1'b0, 3'd2, 32'h0, 32'h0);
    check_out("err1 pre-rst", 1'b0, 1'b1, 32'h0);
    #1;
    HRESETn = 1'b0;
    #1;
    check_out("rst in err1", 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    HRESETn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
